// File: rtl/mux_arb_pkg.sv
// Shared types and sizing helpers for the round-robin mux arbiter.
package mux_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  localparam int unsigned N_DEFAULT = 32;

  function automatic int unsigned sel_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational rotating priority encoder: first set bit of req at or above ptr, wrapping.
module rr_pick
  import mux_arb_pkg::*;
#(
  parameter int unsigned N  = N_DEFAULT,
  parameter int unsigned SW = sel_width(N)
) (
  input  logic [N-1:0]  req,
  input  logic [SW-1:0] ptr,
  output logic          any,
  output logic [SW-1:0] idx
);

  logic [SW-1:0] w_cand;

  assign any = |req;

  // Scan from the farthest offset down so the nearest set bit overwrites last.
  always_comb begin
    idx    = '0;
    w_cand = '0;
    for (int unsigned k = 0; k < N; k++) begin
      w_cand = ptr + SW'(N - 1 - k);
      if (req[w_cand]) begin
        idx = w_cand;
      end
    end
  end

endmodule

// File: rtl/mux32_rr_arbiter.sv
// Round-robin arbiter driving the 32:1 mux select with a registered data output.
// Optional grant timeout is compiled in with `define MUX_ARB_TIMEOUT_EN.
module mux32_rr_arbiter
  import mux_arb_pkg::*;
#(
  parameter int unsigned N        = N_DEFAULT,
  parameter int unsigned SW       = sel_width(N),
  parameter int unsigned MAX_HOLD = 15
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [N-1:0]  req,
  input  logic          rel,
  input  logic [N-1:0]  ip,
  output logic [SW-1:0] s,
  output logic [N-1:0]  gnt,
  output logic          gv,
  output logic          op,
  output logic          to
);

  state_t        r_state, w_state_nxt;
  logic [SW-1:0] r_ptr, w_ptr_nxt;
  logic [SW-1:0] r_s, w_s_nxt;
  logic [N-1:0]  r_gnt, w_gnt_nxt;
  logic          r_gv, w_gv_nxt;
  logic          r_op;
  logic          w_new_grant;
  logic          w_end;
  logic          w_any;
  logic [SW-1:0] w_idx;
  logic [SW-1:0] w_s_inc;
  logic [SW-1:0] w_scan_ptr;
  logic [N-1:0]  w_onehot;

  assign w_s_inc    = r_s + SW'(1);
  // Re-arbitration at a grant end starts just past the owner, making it lowest priority.
  assign w_scan_ptr = (r_state == GRANT) ? w_s_inc : r_ptr;
  assign w_onehot   = {{(N-1){1'b0}}, 1'b1} << w_idx;

  rr_pick #(
    .N  (N),
    .SW (SW)
  ) u_pick (
    .req (req),
    .ptr (w_scan_ptr),
    .any (w_any),
    .idx (w_idx)
  );

`ifdef MUX_ARB_TIMEOUT_EN
  localparam int unsigned HW = $clog2(MAX_HOLD + 1) + 1;
  localparam logic [HW-1:0] HOLD_LAST = HW'(MAX_HOLD - 1);

  logic [HW-1:0] r_hold;
  logic          r_to;
  logic          w_timeout;

  assign w_timeout = (r_state == GRANT) && (r_hold == HOLD_LAST);
  assign w_end     = rel || !req[r_s] || w_timeout;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hold <= '0;
      r_to   <= 1'b0;
    end else begin
      r_to <= w_timeout && !rel && req[r_s];
      if (w_new_grant || !w_gv_nxt) begin
        r_hold <= '0;
      end else if (r_gv) begin
        r_hold <= r_hold + HW'(1);
      end
    end
  end

  assign to = r_to;
`else
  assign w_end = rel || !req[r_s];
  assign to    = 1'b0;
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_ptr_nxt   = r_ptr;
    w_s_nxt     = r_s;
    w_gnt_nxt   = r_gnt;
    w_gv_nxt    = r_gv;
    w_new_grant = 1'b0;
    case (r_state)
      IDLE: begin
        w_gnt_nxt = '0;
        w_gv_nxt  = 1'b0;
        if (w_any) begin
          w_s_nxt     = w_idx;
          w_gnt_nxt   = w_onehot;
          w_gv_nxt    = 1'b1;
          w_new_grant = 1'b1;
          w_state_nxt = GRANT;
        end
      end
      GRANT: begin
        if (w_end) begin
          w_ptr_nxt = w_s_inc;
          if (w_any) begin
            w_s_nxt     = w_idx;
            w_gnt_nxt   = w_onehot;
            w_gv_nxt    = 1'b1;
            w_new_grant = 1'b1;
          end else begin
            w_gnt_nxt   = '0;
            w_gv_nxt    = 1'b0;
            w_state_nxt = IDLE;
          end
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_ptr   <= '0;
      r_s     <= '0;
      r_gnt   <= '0;
      r_gv    <= 1'b0;
      r_op    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_ptr   <= w_ptr_nxt;
      r_s     <= w_s_nxt;
      r_gnt   <= w_gnt_nxt;
      r_gv    <= w_gv_nxt;
      r_op    <= r_gv ? ip[r_s] : 1'b0;
    end
  end

  assign s   = r_s;
  assign gnt = r_gnt;
  assign gv  = r_gv;
  assign op  = r_op;

endmodule

// File: doc/mux32_rr_arbiter.md
# mux32_rr_arbiter

Round-robin arbiter and select sequencer for the 32:1 bit multiplexer datapath. Up to 32 requesters compete for the shared mux. The block grants one requester at a time, drives the 5-bit select `s` with the winner's index, and returns the selected data bit as a registered output. It sits between the requester logic and the mux select, replacing hand-driven select lines.

## Interface
- `N`, default 32: number of requesters; power of two, 2..32.
- `SW`, default $clog2(N) = 5: select width; derived, not overridden.
- `MAX_HOLD`, default 15: maximum grant length in cycles; used only with the timeout feature.

- `clk`  in  1: sole clock, rising edge.
- `rst`  in  1: reset, asynchronous, active-high.
- `req`  in  N: request vector; bit i means requester i wants the mux.
- `rel`  in  1: the current owner releases its grant.
- `ip`  in  N: mux data inputs.
- `s`  out  SW: registered select; index of the current owner.
- `gnt`  out  N: registered one-hot grant; all zeros when idle.
- `gv`  out  1: grant valid.
- `op`  out  1: registered data bit `ip[s]` while `gv` is high, else 0.
- `to`  out  1: one-cycle timeout pulse; tied 0 when the feature is compiled out.

## Operation
- **State register:** two states, IDLE and GRANT.
- **Priority pointer:** `ptr` is SW bits wide and resets to 0. The winner is the first set bit of `req` scanning upward from `ptr`. The scan wraps from N-1 to 0.
- **IDLE:**
  - `gv`=0 and `gnt`=0.
  - If `req` is non-zero, register the winner into `s` and `gnt`, set `gv`=1, and go to GRANT.
- **GRANT:** the grant ends on the first edge at which `rel`=1, or `req[s]`=0, or a timeout fires (when the feature is compiled in).
  - At the end edge, set `ptr` to `s`+1, wrapping N-1 to 0.
  - In that same edge, re-arbitrate over the current `req`, starting from the new `ptr`.
  - If a winner exists, grant it back-to-back with no idle bubble and stay in GRANT.
  - If no winner exists, go to IDLE.
- **Fairness:** the releasing owner has lowest priority in the re-arbitration. It can win again only when no other bit of `req` is set.
- **Grant stability:** `rel` has no effect in IDLE. Requests arriving during a grant never preempt it.
- **`op` register:** `op` <= `gv` ? `ip[s]` : 0, using the registered `s` and `gv`.

## Timing
- **Reset values:** `s`=0, `gnt`=0, `gv`=0, `op`=0, `to`=0, `ptr`=0, state=IDLE, hold counter=0.
- **Reset mid-grant:** takes effect immediately and asynchronously. No release pulse is generated.
- **Request-to-grant latency:** `req` sampled high at edge k gives `gv`/`s`/`gnt` valid after edge k.
- **Release-to-next-grant:** `rel` sampled at edge k switches the owner after edge k, with zero dead cycles.
- **`op` latency:** `op` lags `s` by one cycle. The first `op` of a new grant appears one cycle after the switch.
- **Wrap-around:** owner 31 releasing with `req[0]` set grants index 0.
- **Single requester:** with only requester i active, its own release re-grants i on the same edge. `gv` stays high.
- **Simultaneous events:** `rel`=1 together with `req[s]`=0 counts as a single release.

## Configuration
- **Macro:** `MUX_ARB_TIMEOUT_EN`.
- **Defined:**
  - A hold counter clears on every new grant and increments each cycle `gv`=1.
  - When the count reaches `MAX_HOLD`-1 (the MAX_HOLD-th grant cycle), the next edge ends the grant as if `rel` were asserted.
  - `to` pulses high for exactly one cycle, the cycle after that edge.
  - Timeout and `rel` in the same cycle count as a release; `to` stays low.
- **Undefined:** no counter is built. Grants last until `rel` or the owner's `req` drops, and `to` is constant 0.

## Structure
- **Package `mux_arb_pkg`:** state enum (IDLE, GRANT), default `N`, and the `SW` derivation function.
- **Sub-module `rr_pick`:** combinational rotating priority encoder.
  - Inputs: `req` and `ptr`.
  - Outputs: `any` and index `idx`.
  - Instantiated once; the top holds the FSM, the registers, and the optional counter.

## Test plan
- **Reset:** assert `rst` mid-grant with `s`=7 -> all outputs 0 immediately; after release, `req`=0x1 grants `s`=0 one edge later.
- **Rotation:** `req`=0xFFFFFFFF with `rel` pulsed each grant -> `s` sequence 0,1,2,…,31,0 with `gv` continuously high.
- **Wrap:** owner 31 releases with `req`=0x80000001 -> next `s`=0; then `s`=31 after the next release.
- **Data path:** owner `s`=5, `ip`=0x20 -> `op`=1 one cycle after the grant; `ip`=0 -> `op`=0 next cycle; `gv`=0 -> `op`=0.
- **Owner drop:** owner 3 drops `req[3]` without `rel`, `req`=0x10 -> grant moves to 4 on the same edge, `ptr`=4.
- **Timeout (`MUX_ARB_TIMEOUT_EN`, `MAX_HOLD`=4):** owner holds `req` without `rel` -> grant ends after 4 cycles, `to` pulses once, next requester granted; the same stimulus without the macro holds the grant indefinitely with `to`=0.
